// File: rtl/axi_slave_rd_burst_fifo_pkg.sv
// axi_slave_rd_burst_fifo_pkg: R-channel field widths and FIFO parameter defaults
package axi_slave_rd_burst_fifo_pkg;
    localparam int RDATA_W = 32;
    localparam int RRESP_W = 2;
    localparam int RID_W = 3;
    localparam int R_WORD_W = RDATA_W + RRESP_W + RID_W;
    localparam int DEF_DEPTH_WIDTH = 6;
    localparam int DEF_ALMOST_FULL_NUM = 60;
    localparam int DEF_ALMOST_EMPTY_NUM = 4;
endpackage

// File: rtl/axi_slave_rd_burst_fifo_dpram.sv
// axi_slave_rd_burst_fifo_dpram: one write port, asynchronous read port storage array
module axi_slave_rd_burst_fifo_dpram #(
    parameter int WIDTH = 38,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
    // storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_slave_rd_burst_fifo.sv
// axi_slave_rd_burst_fifo: FWFT R-channel FIFO with watermarks, complete-burst count and flush
module axi_slave_rd_burst_fifo
    import axi_slave_rd_burst_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = R_WORD_W,
    parameter int DEPTH_WIDTH = DEF_DEPTH_WIDTH,
    parameter int ALMOST_FULL_NUM = DEF_ALMOST_FULL_NUM,
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM,
    parameter int BURST_CNT_WIDTH = DEPTH_WIDTH + 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_last,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DEPTH_WIDTH:0]       level,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [BURST_CNT_WIDTH-1:0] burst_cnt,
    output logic                       burst_avail
);
    localparam int AW = DEPTH_WIDTH + 1;
    localparam int DEPTH = 2 ** DEPTH_WIDTH;

    if (!(ALMOST_EMPTY_NUM > 0 && ALMOST_EMPTY_NUM < ALMOST_FULL_NUM && ALMOST_FULL_NUM <= DEPTH)) begin : g_param_err
        $error("axi_slave_rd_burst_fifo: illegal watermark parameters");
    end

    logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt;
    logic [BURST_CNT_WIDTH-1:0] bc_nxt;
    logic push, pop;

    assign push = s_valid && s_ready;
    assign pop = m_valid && m_ready;
    assign level = wr_ptr - rd_ptr;
    assign burst_avail = burst_cnt != '0;

    axi_slave_rd_burst_fifo_dpram #(.WIDTH(DATA_WIDTH + 1), .ADDR_WIDTH(DEPTH_WIDTH)) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[DEPTH_WIDTH-1:0]),
        .wdata ({s_last, s_data}),
        .raddr (rd_ptr[DEPTH_WIDTH-1:0]),
        .rdata ({m_last, m_data})
    );

    // next-state pointers and burst count; flush overrides any handshake in the cycle
    always_comb begin
        wr_nxt = flush ? '0 : wr_ptr + AW'(push);
        rd_nxt = flush ? '0 : rd_ptr + AW'(pop);
        lvl_nxt = wr_nxt - rd_nxt;
        bc_nxt = flush ? '0 : burst_cnt + BURST_CNT_WIDTH'(push && s_last) - BURST_CNT_WIDTH'(pop && m_last);
    end

    // state and registered flags, all derived from the next-state pointers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            burst_cnt <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            almost_full <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            burst_cnt <= bc_nxt;
            s_ready <= !((wr_nxt[AW-1] != rd_nxt[AW-1]) && (wr_nxt[AW-2:0] == rd_nxt[AW-2:0]));
            m_valid <= wr_nxt != rd_nxt;
            almost_full <= lvl_nxt >= AW'(ALMOST_FULL_NUM);
            almost_empty <= lvl_nxt <= AW'(ALMOST_EMPTY_NUM);
        end
    end
endmodule

// File: tb/tb_axi_slave_rd_burst_fifo.sv
// tb_axi_slave_rd_burst_fifo: scoreboard bench for the R-channel burst FIFO
module tb_axi_slave_rd_burst_fifo;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic [36:0] s_data = '0;
    logic s_last = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [36:0] m_data;
    logic m_last;
    logic m_valid;
    logic m_ready = 1'b0;
    logic [6:0] level;
    logic almost_full;
    logic almost_empty;
    logic [6:0] burst_cnt;
    logic burst_avail;

    logic [37:0] q[$];
    int mbc = 0;
    int checks = 0;
    int failures = 0;

    axi_slave_rd_burst_fifo #(
        .DATA_WIDTH(37), .DEPTH_WIDTH(6), .ALMOST_FULL_NUM(60), .ALMOST_EMPTY_NUM(4), .BURST_CNT_WIDTH(7)
    ) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .s_data(s_data), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
        .burst_cnt(burst_cnt), .burst_avail(burst_avail)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // advance one edge; pops are checked against the scoreboard head before the edge
    task automatic tick();
        logic [37:0] head;
        logic was_full;
        was_full = q.size() == 64;
        if (!flush && m_ready && q.size() != 0) begin
            head = q.pop_front();
            checks++;
            if ({m_valid, m_last, m_data} !== {1'b1, head}) begin
                failures++;
                $display("FAIL pop_data got=%h exp=%h", {m_valid, m_last, m_data}, {1'b1, head});
            end
            if (head[37]) mbc--;
        end
        if (!flush && s_valid && !was_full) begin
            q.push_back({s_last, s_data});
            if (s_last) mbc++;
        end
        if (flush) begin
            q.delete();
            mbc = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 70 && q.size() != 0; i++) tick();
        m_ready = 1'b0;
        checks++;
        if (level !== 7'd0 || m_valid !== 1'b0 || burst_cnt !== 7'd0) begin
            failures++;
            $display("FAIL drain level=%0d m_valid=%b burst_cnt=%0d exp 0/0/0", level, m_valid, burst_cnt);
        end
    endtask

    task automatic test_reset();
        #100;
        checks++;
        if ({level, m_valid, s_ready, almost_empty, almost_full, burst_avail} !== {7'd0, 5'b01100}) begin
            failures++;
            $display("FAIL reset_hold level=%0d flags=%b exp 0/01100", level, {m_valid, s_ready, almost_empty, almost_full, burst_avail});
        end
        #100;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({level, m_valid, s_ready, almost_empty, almost_full, burst_avail} !== {7'd0, 5'b01100}) begin
            failures++;
            $display("FAIL reset_release level=%0d flags=%b exp 0/01100", level, {m_valid, s_ready, almost_empty, almost_full, burst_avail});
        end
    endtask

    task automatic test_fill();
        int exp_lvl;
        logic [36:0] top;
        top = 37'h1F_FFFF_FFFF;
        m_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            s_data = top - 37'(i);
            s_last = 1'b0;
            s_valid = 1'b1;
            tick();
            exp_lvl = (i + 1 > 64) ? 64 : i + 1;
            checks++;
            if (level !== 7'(exp_lvl) || almost_full !== (exp_lvl >= 60) || s_ready !== (exp_lvl != 64)) begin
                failures++;
                $display("FAIL fill[%0d] level=%0d af=%b s_ready=%b exp %0d/%b/%b", i, level, almost_full, s_ready, exp_lvl, exp_lvl >= 60, exp_lvl != 64);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_drain();
        int exp_lvl;
        checks++;
        if (q[0][36:0] !== 37'h1F_FFFF_FFFF || q[63][36:0] !== 37'h1F_FFFF_FFC0) begin
            failures++;
            $display("FAIL drain_order first=%h last=%h exp 1fffffffff/1fffffffc0", q[0][36:0], q[63][36:0]);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            exp_lvl = 63 - i;
            checks++;
            if (level !== 7'(exp_lvl) || almost_empty !== (exp_lvl <= 4) || m_valid !== (exp_lvl != 0)) begin
                failures++;
                $display("FAIL drain[%0d] level=%0d ae=%b m_valid=%b exp %0d/%b/%b", i, level, almost_empty, m_valid, exp_lvl, exp_lvl <= 4, exp_lvl != 0);
            end
        end
        m_ready = 1'b0;
    endtask

    task automatic test_steady();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_data = 37'($urandom);
            s_last = 1'b0;
            s_valid = 1'b1;
            tick();
        end
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = {5'h15, 32'($urandom)};
            tick();
            checks++;
            if (level !== 7'd10 || m_valid !== 1'b1) begin
                failures++;
                $display("FAIL steady[%0d] level=%0d m_valid=%b exp 10/1", i, level, m_valid);
            end
        end
        drain();
    endtask

    task automatic test_burst();
        m_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s_data = 37'(i + 100);
            s_last = (i % 4) == 3;
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        checks++;
        if (burst_cnt !== 7'd3 || burst_avail !== 1'b1) begin
            failures++;
            $display("FAIL burst_fill burst_cnt=%0d avail=%b exp 3/1", burst_cnt, burst_avail);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (burst_cnt !== 7'd2 || mbc != 2) begin
            failures++;
            $display("FAIL burst_pop burst_cnt=%0d model=%0d exp 2", burst_cnt, mbc);
        end
        for (int i = 0; i < 3; i++) tick();
        s_data = 37'h0_DEAD_BEEF;
        s_last = 1'b1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b0;
        checks++;
        if (burst_cnt !== 7'd2 || level !== 7'd5) begin
            failures++;
            $display("FAIL burst_coincide burst_cnt=%0d level=%0d exp 2/5", burst_cnt, level);
        end
        drain();
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            s_data = 37'($urandom);
            s_last = (i % 6) == 5;
            s_valid = 1'b1;
            tick();
        end
        checks++;
        if (level !== 7'd30 || burst_cnt !== 7'd5) begin
            failures++;
            $display("FAIL flush_pre level=%0d burst_cnt=%0d exp 30/5", level, burst_cnt);
        end
        s_last = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        checks++;
        if ({level, burst_cnt, m_valid, s_ready, almost_empty, almost_full, burst_avail} !== {7'd0, 7'd0, 5'b01100}) begin
            failures++;
            $display("FAIL flush level=%0d burst_cnt=%0d flags=%b exp 0/0/01100", level, burst_cnt, {m_valid, s_ready, almost_empty, almost_full, burst_avail});
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_data = 37'(i + 7);
            s_last = i == 3;
            s_valid = 1'b1;
            tick();
        end
        s_last = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        q.delete();
        mbc = 0;
        checks++;
        if ({level, burst_cnt, m_valid, s_ready, almost_empty, almost_full, burst_avail} !== {7'd0, 7'd0, 5'b01100}) begin
            failures++;
            $display("FAIL reset_mid level=%0d burst_cnt=%0d flags=%b exp 0/0/01100", level, burst_cnt, {m_valid, s_ready, almost_empty, almost_full, burst_avail});
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        s_data = 37'h0A_5A5A_5A5A;
        s_last = 1'b1;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last = 1'b0;
        checks++;
        if ({m_valid, m_last, m_data, level, burst_cnt} !== {2'b11, 37'h0A_5A5A_5A5A, 7'd1, 7'd1}) begin
            failures++;
            $display("FAIL reset_readback v=%b l=%b d=%h level=%0d bc=%0d exp 1/1/0a5a5a5a5a/1/1", m_valid, m_last, m_data, level, burst_cnt);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_steady();
        test_burst();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
